// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between a CPU byte source and a
// debug/trace byte source, each buffered in its own DEPTH-entry FIFO.
// A round-robin scheduler pops one byte at a time and runs the
// tx_en / tx_busy handshake, with a timeout if tx_busy never rises.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   cpu_wr_en, cpu_wr_data    CPU FIFO push
//   dbg_wr_en, dbg_wr_data    debug FIFO push
//   ovf_clr                   clears cpu_ovf, dbg_ovf and ack_err
//   cpu_full, dbg_full        registered FIFO-full flags
//   cpu_level                 registered CPU FIFO occupancy
//   idle                      FSM idle and both FIFOs empty
//   cpu_ovf, dbg_ovf          sticky dropped-write flags
//   ack_err                   sticky launch-timeout flag
//   tx_en, tx_data            start pulse and byte to uart_tx
//   tx_busy                   uart_tx busy
module uart_tx_arbiter #(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_wr_en,
  input  logic [7:0]             cpu_wr_data,
  input  logic                   dbg_wr_en,
  input  logic [7:0]             dbg_wr_data,
  input  logic                   ovf_clr,
  output logic                   cpu_full,
  output logic                   dbg_full,
  output logic [$clog2(DEPTH):0] cpu_level,
  output logic                   idle,
  output logic                   cpu_ovf,
  output logic                   dbg_ovf,
  output logic                   ack_err,
  output logic                   tx_en,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_ACK,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_n;
  logic            r_last_dbg;

  logic [7:0]      r_cpu_mem [DEPTH];
  logic [7:0]      r_dbg_mem [DEPTH];
  logic [PW-1:0]   r_cpu_wp;
  logic [PW-1:0]   r_cpu_rp;
  logic [PW-1:0]   r_dbg_wp;
  logic [PW-1:0]   r_dbg_rp;

  logic            r_cpu_full;
  logic            r_dbg_full;
  logic [PW-1:0]   r_cpu_level;
  logic            r_idle;
  logic            r_cpu_ovf;
  logic            r_dbg_ovf;
  logic            r_ack_err;
  logic            r_tx_en;
  logic [7:0]      r_tx_data;

  logic            w_cpu_empty;
  logic            w_dbg_empty;
  logic            w_cpu_push;
  logic            w_dbg_push;
  logic            w_cpu_drop;
  logic            w_dbg_drop;
  logic            w_pop_cpu;
  logic            w_pop_dbg;
  logic            w_launch;
  logic            w_timeout;
  logic [7:0]      w_head;
  logic [PW-1:0]   w_cpu_wp_n;
  logic [PW-1:0]   w_cpu_rp_n;
  logic [PW-1:0]   w_dbg_wp_n;
  logic [PW-1:0]   w_dbg_rp_n;
  logic            w_cpu_full_n;
  logic            w_dbg_full_n;
  logic            w_idle_n;

  assign w_cpu_empty = (r_cpu_wp == r_cpu_rp);
  assign w_dbg_empty = (r_dbg_wp == r_dbg_rp);

  // Full is judged on the registered flag, so a write to a full FIFO
  // is dropped even when the scheduler frees a slot this same cycle.
  assign w_cpu_push = cpu_wr_en & ~r_cpu_full;
  assign w_dbg_push = dbg_wr_en & ~r_dbg_full;
  assign w_cpu_drop = cpu_wr_en & r_cpu_full;
  assign w_dbg_drop = dbg_wr_en & r_dbg_full;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pop_cpu = 1'b0;
    w_pop_dbg = 1'b0;
    w_launch  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!tx_busy && !(w_cpu_empty && w_dbg_empty)) begin
          w_launch  = 1'b1;
          w_state_n = S_LAUNCH;
          // On a tie the source that did not win last time goes.
          if (!w_cpu_empty && (w_dbg_empty || r_last_dbg)) begin
            w_pop_cpu = 1'b1;
          end else begin
            w_pop_dbg = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        w_state_n = S_ACK;
        w_cnt_n   = CW'(ACK_TIMEOUT);
      end
      S_ACK: begin
        if (tx_busy) begin
          w_state_n = S_DRAIN;
        end else if (r_cnt <= CW'(1)) begin
          // Counter reaches zero on this cycle: give up.
          w_timeout = 1'b1;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign w_head = w_pop_cpu ? r_cpu_mem[r_cpu_rp[AW-1:0]]
                            : r_dbg_mem[r_dbg_rp[AW-1:0]];

  assign w_cpu_wp_n = r_cpu_wp + PW'(w_cpu_push);
  assign w_cpu_rp_n = r_cpu_rp + PW'(w_pop_cpu);
  assign w_dbg_wp_n = r_dbg_wp + PW'(w_dbg_push);
  assign w_dbg_rp_n = r_dbg_rp + PW'(w_pop_dbg);

  // Same index with differing wrap bit means full.
  assign w_cpu_full_n = (w_cpu_wp_n[AW] != w_cpu_rp_n[AW]) &&
                        (w_cpu_wp_n[AW-1:0] == w_cpu_rp_n[AW-1:0]);
  assign w_dbg_full_n = (w_dbg_wp_n[AW] != w_dbg_rp_n[AW]) &&
                        (w_dbg_wp_n[AW-1:0] == w_dbg_rp_n[AW-1:0]);

  assign w_idle_n = (w_state_n == S_IDLE) &&
                    (w_cpu_wp_n == w_cpu_rp_n) &&
                    (w_dbg_wp_n == w_dbg_rp_n);

  always_ff @(posedge clk) begin
    if (w_cpu_push) begin
      r_cpu_mem[r_cpu_wp[AW-1:0]] <= cpu_wr_data;
    end
    if (w_dbg_push) begin
      r_dbg_mem[r_dbg_wp[AW-1:0]] <= dbg_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_dbg  <= 1'b1;
      r_cpu_wp    <= '0;
      r_cpu_rp    <= '0;
      r_dbg_wp    <= '0;
      r_dbg_rp    <= '0;
      r_cpu_full  <= 1'b0;
      r_dbg_full  <= 1'b0;
      r_cpu_level <= '0;
      r_idle      <= 1'b1;
      r_cpu_ovf   <= 1'b0;
      r_dbg_ovf   <= 1'b0;
      r_ack_err   <= 1'b0;
      r_tx_en     <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_cpu_wp    <= w_cpu_wp_n;
      r_cpu_rp    <= w_cpu_rp_n;
      r_dbg_wp    <= w_dbg_wp_n;
      r_dbg_rp    <= w_dbg_rp_n;
      r_cpu_full  <= w_cpu_full_n;
      r_dbg_full  <= w_dbg_full_n;
      r_cpu_level <= w_cpu_wp_n - w_cpu_rp_n;
      r_idle      <= w_idle_n;
      // A new event outranks a clear in the same cycle.
      r_cpu_ovf   <= w_cpu_drop | (r_cpu_ovf & ~ovf_clr);
      r_dbg_ovf   <= w_dbg_drop | (r_dbg_ovf & ~ovf_clr);
      r_ack_err   <= w_timeout | (r_ack_err & ~ovf_clr);
      r_tx_en     <= w_launch;
      if (w_pop_cpu) begin
        r_last_dbg <= 1'b0;
      end else if (w_pop_dbg) begin
        r_last_dbg <= 1'b1;
      end
      if (w_launch) begin
        r_tx_data <= w_head;
      end
    end
  end

  assign cpu_full  = r_cpu_full;
  assign dbg_full  = r_dbg_full;
  assign cpu_level = r_cpu_level;
  assign idle      = r_idle;
  assign cpu_ovf   = r_cpu_ovf;
  assign dbg_ovf   = r_dbg_ovf;
  assign ack_err   = r_ack_err;
  assign tx_en     = r_tx_en;
  assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
  localparam int DEPTH = 4;
  localparam int ACK_TIMEOUT = 4;
  localparam int FRAME = 20;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk = 0;
  logic rst = 0;
  logic cpu_wr_en = 0;
  logic [7:0] cpu_wr_data = 0;
  logic dbg_wr_en = 0;
  logic [7:0] dbg_wr_data = 0;
  logic ovf_clr = 0;
  logic tx_busy = 0;
  logic cpu_full, dbg_full, idle;
  logic cpu_ovf, dbg_ovf, ack_err, tx_en;
  logic [LW-1:0] cpu_level;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DEPTH(DEPTH),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_wr_en(cpu_wr_en),
    .cpu_wr_data(cpu_wr_data),
    .dbg_wr_en(dbg_wr_en),
    .dbg_wr_data(dbg_wr_data),
    .ovf_clr(ovf_clr),
    .cpu_full(cpu_full),
    .dbg_full(dbg_full),
    .cpu_level(cpu_level),
    .idle(idle),
    .cpu_ovf(cpu_ovf),
    .dbg_ovf(dbg_ovf),
    .ack_err(ack_err),
    .tx_en(tx_en),
    .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter: mode 0 normal frame, 1 dead, 2 busy held high.
  int mode = 0;
  int bcnt = 0;
  logic [7:0] sent[$];

  always @(posedge clk) begin
    if (tx_en) sent.push_back(tx_data);
    if (mode == 2) begin
      tx_busy <= 1'b1;
    end else if (mode == 1) begin
      tx_busy <= 1'b0;
      bcnt <= 0;
    end else if (tx_en) begin
      tx_busy <= 1'b1;
      bcnt <= FRAME;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      bcnt <= 0;
      tx_busy <= 1'b0;
    end
  end

  // Model: byte queues plus the link phase
  // (0 free, 1 pulse out, 2 awaiting busy, 3 draining).
  logic [7:0] cq[$];
  logic [7:0] dq[$];
  bit m_last_dbg;
  int m_ph;
  int m_age;
  bit m_cfull, m_dfull, m_cdrop, m_ddrop, m_tout, m_go;
  logic e_tx_en, e_idle, e_cfull, e_dfull;
  logic e_covf, e_dovf, e_aerr;
  logic [7:0] e_tx_data;
  int e_level;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cq.delete();
      dq.delete();
      m_last_dbg = 1;
      m_ph = 0;
      m_age = 0;
      e_tx_en = 0;
      e_tx_data = 0;
      e_idle = 1;
      e_cfull = 0;
      e_dfull = 0;
      e_covf = 0;
      e_dovf = 0;
      e_aerr = 0;
      e_level = 0;
    end else begin
      m_cfull = (cq.size() == DEPTH);
      m_dfull = (dq.size() == DEPTH);
      m_cdrop = 0;
      m_ddrop = 0;
      m_tout = 0;
      m_go = 0;
      case (m_ph)
        0: if (!tx_busy && (cq.size() > 0 || dq.size() > 0)) begin
          m_go = 1;
          m_ph = 1;
          if (cq.size() > 0 && (dq.size() == 0 || m_last_dbg)) begin
            e_tx_data = cq.pop_front();
            m_last_dbg = 0;
          end else begin
            e_tx_data = dq.pop_front();
            m_last_dbg = 1;
          end
        end
        1: begin
          m_ph = 2;
          m_age = 0;
        end
        2: begin
          m_age++;
          if (tx_busy) m_ph = 3;
          else if (m_age == ACK_TIMEOUT) begin
            m_tout = 1;
            m_ph = 0;
          end
        end
        default: if (!tx_busy) m_ph = 0;
      endcase
      if (cpu_wr_en) begin
        if (m_cfull) m_cdrop = 1;
        else cq.push_back(cpu_wr_data);
      end
      if (dbg_wr_en) begin
        if (m_dfull) m_ddrop = 1;
        else dq.push_back(dbg_wr_data);
      end
      e_tx_en = m_go;
      e_covf = m_cdrop | (e_covf & !ovf_clr);
      e_dovf = m_ddrop | (e_dovf & !ovf_clr);
      e_aerr = m_tout | (e_aerr & !ovf_clr);
      e_cfull = (cq.size() == DEPTH);
      e_dfull = (dq.size() == DEPTH);
      e_level = cq.size();
      e_idle = (m_ph == 0) && cq.size() == 0 && dq.size() == 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("m_tx_en", tx_en, e_tx_en);
      check("m_tx_data", tx_data, e_tx_data);
      check("m_idle", idle, e_idle);
      check("m_cpu_full", cpu_full, e_cfull);
      check("m_dbg_full", dbg_full, e_dfull);
      check("m_cpu_level", cpu_level, e_level);
      check("m_cpu_ovf", cpu_ovf, e_covf);
      check("m_dbg_ovf", dbg_ovf, e_dovf);
      check("m_ack_err", ack_err, e_aerr);
    end
  end

  task automatic do_reset();
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk_on = 1;
    rst = 0;
  endtask

  task automatic wait_tx(int n, int bound);
    int k = 0;
    while (sent.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("wait_tx", (sent.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_quiet(int bound);
    int k = 0;
    while (!(idle && !tx_busy) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("wait_quiet", (idle && !tx_busy) ? 1 : 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    do_reset();
    check("rst_idle", idle, 1);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_level", cpu_level, 0);
    check("rst_ovf", cpu_ovf, 0);
    check("rst_ack_err", ack_err, 0);

    // 1: single byte, latency and pulse width
    sent.delete();
    mode = 0;
    cpu_wr_en = 1;
    cpu_wr_data = 8'h41;
    @(negedge clk);
    cpu_wr_en = 0;
    check("t1_no_en_yet", tx_en, 0);
    check("t1_level", cpu_level, 1);
    @(negedge clk);
    check("t1_en", tx_en, 1);
    check("t1_data", tx_data, 8'h41);
    @(negedge clk);
    check("t1_pulse_end", tx_en, 0);
    check("t1_data_hold", tx_data, 8'h41);
    wait_quiet(60);
    check("t1_count", sent.size(), 1);
    check("t1_byte", sent[0], 8'h41);
    check("t1_idle", idle, 1);

    // 2: round robin between both sources
    do_reset();
    sent.delete();
    mode = 2;
    @(negedge clk);
    cpu_wr_en = 1; cpu_wr_data = 8'h01;
    dbg_wr_en = 1; dbg_wr_data = 8'hA1;
    @(negedge clk);
    cpu_wr_data = 8'h02;
    dbg_wr_data = 8'hA2;
    @(negedge clk);
    cpu_wr_en = 0;
    dbg_wr_en = 0;
    check("t2_level2", cpu_level, 2);
    mode = 0;
    wait_tx(1, 60);
    check("t2_level1", cpu_level, 1);
    wait_tx(3, 120);
    check("t2_level0", cpu_level, 0);
    wait_tx(4, 60);
    wait_quiet(60);
    check("t2_count", sent.size(), 4);
    check("t2_b0", sent[0], 8'h01);
    check("t2_b1", sent[1], 8'hA1);
    check("t2_b2", sent[2], 8'h02);
    check("t2_b3", sent[3], 8'hA2);

    // 3: CPU overflow while transmitter busy
    do_reset();
    sent.delete();
    mode = 2;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cpu_wr_en = 1;
      cpu_wr_data = 8'h10 + 8'(i);
      @(negedge clk);
      if (i == 3) begin
        check("t3_full", cpu_full, 1);
        check("t3_no_ovf", cpu_ovf, 0);
        check("t3_level4", cpu_level, 4);
      end
    end
    cpu_wr_en = 0;
    check("t3_ovf", cpu_ovf, 1);
    check("t3_still_full", cpu_full, 1);
    mode = 0;
    wait_tx(4, 200);
    wait_quiet(60);
    check("t3_count", sent.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t3_byte", sent[k], 8'h10 + k);
    end
    check("t3_ovf_sticky", cpu_ovf, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    check("t3_ovf_clr", cpu_ovf, 0);

    // 4: dead transmitter, acknowledge timeout
    do_reset();
    sent.delete();
    mode = 1;
    @(negedge clk);
    cpu_wr_en = 1;
    cpu_wr_data = 8'h55;
    @(negedge clk);
    cpu_wr_en = 0;
    @(negedge clk);
    check("t4_en", tx_en, 1);
    check("t4_data", tx_data, 8'h55);
    repeat (4) @(negedge clk);
    check("t4_no_err_yet", ack_err, 0);
    @(negedge clk);
    check("t4_err", ack_err, 1);
    check("t4_idle", idle, 1);
    repeat (5) @(negedge clk);
    check("t4_one_pulse", sent.size(), 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    check("t4_err_clr", ack_err, 0);

    // 5: async reset while draining with bytes queued
    do_reset();
    sent.delete();
    mode = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_wr_en = 1;
      cpu_wr_data = 8'h60 + 8'(i);
      @(negedge clk);
    end
    cpu_wr_en = 0;
    repeat (3) @(negedge clk);
    check("t5_level3", cpu_level, 3);
    check("t5_data", tx_data, 8'h60);
    #2 rst = 1;
    #1;
    check("t5_rst_tx_en", tx_en, 0);
    check("t5_rst_data", tx_data, 0);
    check("t5_rst_level", cpu_level, 0);
    check("t5_rst_idle", idle, 1);
    check("t5_rst_full", cpu_full, 0);
    @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    check("t5_no_more_tx", sent.size(), 1);
    check("t5_idle", idle, 1);

    // 6: overflow beats a same-cycle clear
    do_reset();
    sent.delete();
    mode = 2;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dbg_wr_en = 1;
      dbg_wr_data = 8'hB0 + 8'(i);
      @(negedge clk);
    end
    check("t6_full", dbg_full, 1);
    check("t6_no_ovf", dbg_ovf, 0);
    ovf_clr = 1;
    dbg_wr_data = 8'hBF;
    @(negedge clk);
    dbg_wr_en = 0;
    check("t6_ovf_wins", dbg_ovf, 1);
    @(negedge clk);
    ovf_clr = 0;
    check("t6_clr", dbg_ovf, 0);
    dbg_wr_en = 1;
    @(negedge clk);
    ovf_clr = 1;
    @(negedge clk);
    dbg_wr_en = 0;
    ovf_clr = 0;
    check("t6_ovf_hold", dbg_ovf, 1);
    mode = 0;
    wait_tx(4, 200);
    wait_quiet(60);
    check("t6_count", sent.size(), 4);
    check("t6_b0", sent[0], 8'hB0);
    check("t6_b3", sent[3], 8'hB3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx transmitter between two byte sources: CPU MMIO writes to the UART data register, and a hardware debug/trace source.
- Each source has its own DEPTH-entry byte FIFO. A round-robin scheduler pops one byte at a time and sequences the tx_en / tx_busy handshake with uart_tx.
- Sits between the peripheral address decode and the uart_tx instance in the top level.

Parameters:
- DEPTH, 4: entries per source FIFO; power of 2, minimum 2.
- ACK_TIMEOUT, 4: cycles to wait for tx_busy to rise after a launch before abandoning the handshake.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- cpu_wr_en  input  1  push cpu_wr_data into the CPU FIFO
- cpu_wr_data  input  8  CPU byte
- dbg_wr_en  input  1  push dbg_wr_data into the debug FIFO
- dbg_wr_data  input  8  debug byte
- ovf_clr  input  1  clears both overflow flags
- cpu_full  output  1  CPU FIFO full
- dbg_full  output  1  debug FIFO full
- cpu_level  output  $clog2(DEPTH)+1  CPU FIFO occupancy
- idle  output  1  both FIFOs empty and FSM in IDLE
- cpu_ovf  output  1  sticky: CPU write dropped
- dbg_ovf  output  1  sticky: debug write dropped
- ack_err  output  1  sticky: launch timed out; cleared by ovf_clr
- tx_en  output  1  single-cycle start pulse to uart_tx
- tx_data  output  8  byte to uart_tx; valid while tx_en is high
- tx_busy  input  1  uart_tx busy

Behaviour:
- Reset is asynchronous, active-high, applied immediately on assertion. All state clears:
  - FIFOs empty.
  - tx_en=0, tx_data=0.
  - full flags=0, cpu_level=0, idle=1.
  - ovf flags=0, ack_err=0.
  - FSM=IDLE, last_grant=DBG, so the CPU wins the first tie.
- Reset mid-transmission discards all queued bytes. The byte already handed to uart_tx is not recalled.
- FIFOs:
  - Each FIFO is circular, with pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - full/level are registered, computed from pointer state.
  - A write with full=1 (sampled at the start of the cycle) is dropped and sets the matching ovf flag, even if the scheduler pops that FIFO in the same cycle.
  - A push and a pop in the same cycle on a non-full FIFO both take effect; level is unchanged.
- Overflow flags:
  - ovf flags stay set until an ovf_clr cycle.
  - If ovf_clr and a new overflow occur in the same cycle, the overflow wins and the flag stays 1.
- FSM states:
  - IDLE: if tx_busy=0 and at least one FIFO is non-empty, select a source.
    - Only one non-empty: select it.
    - Both non-empty: select the source opposite last_grant.
    - Pop the selected head into tx_data, set tx_en=1, update last_grant, go to LAUNCH.
    - If tx_busy=1, stay in IDLE.
  - LAUNCH (one cycle): tx_en returns to 0. Go to ACK and load the timeout counter with ACK_TIMEOUT.
  - ACK:
    - tx_busy=1: go to DRAIN.
    - Counter reaches 0 with tx_busy still 0: set ack_err, go to IDLE.
    - Otherwise decrement the counter.
  - DRAIN: wait for tx_busy=0, then go to IDLE.
- Latency: a byte written into an empty FIFO (FSM in IDLE, tx_busy=0) produces tx_en in the next cycle after wr_en is sampled.
- Back-to-back bytes: minimum spacing is the uart_tx frame time plus 3 cycles (IDLE, LAUNCH, and ACK overhead).
- tx_en is never high for two consecutive cycles, and never high while the FSM is outside the IDLE→LAUNCH edge.
- tx_data holds its last value when tx_en=0.
- idle is registered: 1 when the FSM is in IDLE and both FIFOs are empty after the current cycle's pops and pushes.

Test Plan:
1. Reset, then cpu_wr_en with 0x41, tx_busy model rising 1 cycle after tx_en and holding for 20 cycles -> tx_en pulses exactly one cycle after the write, tx_data=0x41; idle returns to 1 after tx_busy falls.
2. Both FIFOs loaded in one cycle (CPU 0x01,0x02; debug 0xA1,0xA2) -> transmit order is 0x01, 0xA1, 0x02, 0xA2; cpu_level steps 2→1→0.
3. With tx_busy held at 1, write 5 CPU bytes 0x10..0x14 at DEPTH=4 -> cpu_full=1 after the 4th write and cpu_ovf=1 after the 5th; release tx_busy -> 0x10..0x13 are sent and 0x14 is lost.
4. tx_busy tied to 0 (dead transmitter), one byte 0x55 queued -> one tx_en pulse, then ack_err=1 after ACK_TIMEOUT=4 cycles in ACK, FSM back in IDLE; ovf_clr -> ack_err=0.
5. Assert rst asynchronously between clock edges while in DRAIN with 3 bytes queued -> all outputs take their reset values immediately, cpu_level=0, no tx_en pulse after release.
6. ovf_clr in the same cycle as a write to a full debug FIFO -> dbg_ovf remains 1.
